ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 117 +++++++++++
 tb/tb_ifetch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: PC generator plus a DEPTH-entry prefetch queue of {pc, instr} pairs.
// Define IFETCH_STATS_EN to add the fetched_cnt / stall_cnt statistics outputs.
module ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic [31:0]              pc_o,
  input  logic [31:0]              instr_i,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]              fetched_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        state, state_next;
  logic [PW-1:0] head, tail;
  logic [31:0]   pc;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic          fetching, full, pop, push;

  // FSM state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state; a pending redirect keeps FETCH alive so the restart is not lost.
  // NOTE: defaulting state_next before the case keeps this purely combinational (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run)                state_next = FETCH;
      FETCH:   if (!run && !redirect)  state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // FSM outputs: dropping run stops pushes in the same cycle.
  always_comb begin
    fetching = (state == FETCH) && run;
  end

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect;
  assign push      = fetching && !redirect && (!full || pop);

  assign pc_o      = pc;
  assign out_instr = mem_instr[head];
  assign out_pc    = mem_pc[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC & 32'hFFFF_FFFC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      pc    <= redirect_pc & 32'hFFFF_FFFC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage is deliberately not reset; occupancy alone defines
  // validity, so stale contents are never observable and plain RAM can be used.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail] <= instr_i;
      mem_pc[tail]    <= pc;
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (push) fetched_cnt <= fetched_cnt + 32'd1;
      if ((state == FETCH) && !push && !redirect) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: scoreboard of expected fetch addresses,
// popped whenever decode accepts the queue head.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset, run, redirect, out_ready, out_valid;
  logic [31:0] pc_o, instr_i, redirect_pc, out_instr, out_pc;
  logic [2:0]  count;

  logic        rst1, run1, out_ready1, out_valid1;
  logic [31:0] pc_o1, instr1, out_instr1, out_pc1;
  logic [2:0]  count1;

`ifdef IFETCH_STATS_EN
  logic [31:0] fetched_cnt, stall_cnt, fetched_cnt1, stall_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory model: word i holds 32'h1000 + i.
  assign instr_i = 32'h1000 + {2'b00, pc_o[31:2]};
  assign instr1  = 32'h1000 + {2'b00, pc_o1[31:2]};

  ifetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .run(run), .pc_o(pc_o), .instr_i(instr_i),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .count(count)
`ifdef IFETCH_STATS_EN
    , .fetched_cnt(fetched_cnt), .stall_cnt(stall_cnt)
`endif
  );

  ifetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(rst1), .run(run1), .pc_o(pc_o1), .instr_i(instr1),
    .redirect(1'b0), .redirect_pc(32'h0), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_instr(out_instr1), .out_pc(out_pc1), .count(count1)
`ifdef IFETCH_STATS_EN
    , .fetched_cnt(fetched_cnt1), .stall_cnt(stall_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  // One clock cycle; if the head is being accepted, compare it with the scoreboard first.
  task automatic tick();
    logic [31:0] e;
    if (out_valid && out_ready && !redirect) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check("sb_pc", out_pc, e);
      check("sb_instr", out_instr, 32'h1000 + {2'b00, e[31:2]});
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    rst1 = 1'b1; run1 = 1'b0; out_ready1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pc", pc_o, 32'h0);

    // Streaming fetch with decode always ready.
    reset = 1'b0; run = 1'b1; out_ready = 1'b1;
    sb_restart(32'h0);
    tick();
    check("latency_valid0", 32'(out_valid), 32'd0);
    tick();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_pc", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("stream_count", 32'(count), 32'd1);

    // Build up three entries, then redirect to a misaligned target.
    out_ready = 1'b0;
    tick();
    tick();
    check("pre_redir_count", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0203; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("redir_count", 32'(count), 32'd0);
    check("redir_pc", pc_o, 32'h200);
    check("redir_valid", 32'(out_valid), 32'd0);
    sb_restart(32'h200);
    tick();
    check("redir_head_pc", out_pc, 32'h200);
    for (int i = 0; i < 3; i++) tick();

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_pc", pc_o, 32'h0);
    check("async_count", 32'(count), 32'd0);
`ifdef IFETCH_STATS_EN
    check("stats_clear", fetched_cnt, 32'd0);
`endif
    @(negedge clk);

    // Saturate the queue, then drain it at full rate.
    reset = 1'b0; run = 1'b1; out_ready = 1'b0;
    sb_restart(32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("full_count", 32'(count), 32'd4);
    check("full_pc_hold", pc_o, 32'h10);
    check("full_head_stable", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("full_stream_count", 32'(count), 32'd4);
    end

    // Stop fetching: pushes cease at once, queued entries still drain.
    run = 1'b0;
    tick();
    check("stop_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) tick();
    check("drained_count", 32'(count), 32'd0);
    check("drained_valid", 32'(out_valid), 32'd0);
    check("stop_pc", pc_o, 32'h28);

    // PC wrap across 2^32 on the second instance.
    rst1 = 1'b0; run1 = 1'b1; out_ready1 = 1'b1;
    tick();
    tick();
    check("wrap_pc0", out_pc1, 32'hFFFF_FFF8);
    check("wrap_instr0", out_instr1, 32'h1000 + 32'h3FFF_FFFE);
    tick();
    check("wrap_pc1", out_pc1, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc2", out_pc1, 32'h0000_0000);
    check("wrap_valid", 32'(out_valid1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
